// File: rtl/entropy_src_pkg.sv
// Shared entropy_src definitions used by the pipeline-control block:
// the control FSM state type, default sequencing constants and a small
// width helper.
package entropy_src_pkg;

  // One-hot encoding: each state bit is the output that state drives,
  // so the state register itself provides registered outputs.
  //   bit 0 ready, bit 1 ht_clr, bit 2 pipe_en, bit 3 fsm_idle_req, bit 4 fifo_clr
  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StHtClr    = 5'b00010,
    StRun      = 5'b00100,
    StWaitIdle = 5'b01000,
    StFifoClr  = 5'b10000
  } entropy_src_pipe_ctrl_state_e;

  localparam int HtClrCyclesDef   = 2;
  localparam int FifoClrCyclesDef = 1;
  localparam int IdleTimeoutDef   = 16;

  // Largest of three values, used to size the shared counter width.
  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/entropy_src_pipe_ctrl_timer.sv
// Loadable down-counter with a zero flag. Load has priority over
// decrement; the count holds at zero rather than wrapping.
module entropy_src_pipe_ctrl_timer #(
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  // Counter register: load, else decrement while non-zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/entropy_src_pipe_ctrl.sv
// entropy_src pipeline control: sequences the delayed enable level into
// health-test clear, pipeline enable, FSM idle request and FIFO clear.
// Optional idle-wait timeout: ENTROPY_SRC_PIPE_CTRL_TIMEOUT_EN.
//
// Enable/ready: ready_o high means the block is in Idle; an enable_i seen
// high at a clock edge while ready_o is high is accepted and starts a full
// sequence. enable_i is ignored in every other state.
module entropy_src_pipe_ctrl import entropy_src_pkg::*; #(
  parameter int HtClrCycles   = HtClrCyclesDef,
  parameter int FifoClrCycles = FifoClrCyclesDef,
  parameter int IdleTimeout   = IdleTimeoutDef,
  parameter int CntW          = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            fsm_idle_i,
  output logic            ht_clr_o,
  output logic            pipe_en_o,
  output logic            fsm_idle_req_o,
  output logic            fifo_clr_o,
  output logic            ready_o,
  output logic            timeout_o,
  output logic [CntW-1:0] enable_cnt_o
);

  // One width for both timer instances so they are identical copies.
  localparam int PhW = $clog2(max3(HtClrCycles, FifoClrCycles, IdleTimeout) + 1);

  entropy_src_pipe_ctrl_state_e state_q;
  logic [CntW-1:0] enable_cnt_q;
  logic            ph_load, ph_dec, ph_zero;
  logic [PhW-1:0]  ph_val;
  logic            to_fire;

  // Phase counter control: load on entry to HtClr / FifoClr, count down inside them.
  always_comb begin
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = '0;
    case (state_q)
      StIdle: begin
        if (enable_i) begin
          ph_load = 1'b1;
          ph_val  = PhW'(HtClrCycles - 1);
        end
      end
      StHtClr, StFifoClr: ph_dec = !ph_zero;
      StWaitIdle: begin
        if (fsm_idle_i || to_fire) begin
          ph_load = 1'b1;
          ph_val  = PhW'(FifoClrCycles - 1);
        end
      end
      default: ;
    endcase
  end

  entropy_src_pipe_ctrl_timer #(.Width(PhW)) u_phase_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (ph_dec),
    .zero_o     (ph_zero)
  );

`ifdef ENTROPY_SRC_PIPE_CTRL_TIMEOUT_EN
  logic wait_entry, to_dec, to_zero, timeout_q;

  // Timer restarts on every entry into WaitIdle, from Run or from HtClr.
  assign wait_entry = ((state_q == StRun) && !enable_i) ||
                      ((state_q == StHtClr) && ph_zero && !enable_i);
  assign to_dec     = (state_q == StWaitIdle) && !to_zero;
  assign to_fire    = (state_q == StWaitIdle) && to_zero && !fsm_idle_i;

  entropy_src_pipe_ctrl_timer #(.Width(PhW)) u_timeout_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (wait_entry),
    .load_val_i (PhW'(IdleTimeout - 1)),
    .dec_i      (to_dec),
    .zero_o     (to_zero)
  );

  // Timeout pulse lines up with the first FifoClr cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Main sequencing FSM plus the saturating accepted-enable counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      enable_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_q <= StHtClr;
            if (enable_cnt_q != '1) begin
              enable_cnt_q <= enable_cnt_q + 1'b1;
            end
          end
        end
        StHtClr: begin
          if (ph_zero) begin
            state_q <= enable_i ? StRun : StWaitIdle;
          end
        end
        StRun: begin
          if (!enable_i) begin
            state_q <= StWaitIdle;
          end
        end
        StWaitIdle: begin
          if (fsm_idle_i || to_fire) begin
            state_q <= StFifoClr;
          end
        end
        StFifoClr: begin
          if (ph_zero) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o        = state_q[0];
  assign ht_clr_o       = state_q[1];
  assign pipe_en_o      = state_q[2];
  assign fsm_idle_req_o = state_q[3];
  assign fifo_clr_o     = state_q[4];
  assign enable_cnt_o   = enable_cnt_q;

endmodule

// File: tb/tb_entropy_src_pipe_ctrl.sv
// Directed bench for entropy_src_pipe_ctrl with default parameters.
module tb_entropy_src_pipe_ctrl;

  // Expected output vectors {ready, ht_clr, pipe_en, idle_req, fifo_clr, timeout}
  localparam logic [5:0] O_IDLE = 6'b100000;
  localparam logic [5:0] O_HT   = 6'b010000;
  localparam logic [5:0] O_RUN  = 6'b001000;
  localparam logic [5:0] O_WAIT = 6'b000100;
  localparam logic [5:0] O_FIFO = 6'b000010;
  localparam logic [5:0] O_TO   = 6'b000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fsm_idle = 1'b0;
  logic       ht_clr, pipe_en, idle_req, fifo_clr, ready, timeout;
  logic [7:0] enable_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // clock / reset
  always #5 clk = ~clk;

  entropy_src_pipe_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .fsm_idle_i     (fsm_idle),
    .ht_clr_o       (ht_clr),
    .pipe_en_o      (pipe_en),
    .fsm_idle_req_o (idle_req),
    .fifo_clr_o     (fifo_clr),
    .ready_o        (ready),
    .timeout_o      (timeout),
    .enable_cnt_o   (enable_cnt)
  );

  function automatic logic [5:0] outs();
    return {ready, ht_clr, pipe_en, idle_req, fifo_clr, timeout};
  endfunction

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_o(input string tag, input logic [5:0] exp);
    chk(tag, 32'(outs()), 32'(exp));
  endtask

  initial begin
    // reset state
    step(); step();
    chk_o("reset_outs", O_IDLE);
    chk("reset_cnt", 32'(enable_cnt), 32'd0);
    rst = 1'b0;
    step(); step();
    chk_o("idle_after_reset", O_IDLE);

    // enable rises: HtClr for 2 cycles, then Run
    enable = 1'b1;
    step(); chk_o("ht1", O_HT); chk("cnt1", 32'(enable_cnt), 32'd1);
    step(); chk_o("ht2", O_HT);
    step(); chk_o("run1", O_RUN);
    step(); step(); chk_o("run3", O_RUN);

    // enable falls: WaitIdle until fsm_idle, then 1 cycle FifoClr, then Idle
    enable = 1'b0;
    step(); chk_o("wait1", O_WAIT);
    step(); step(); chk_o("wait3", O_WAIT);
    fsm_idle = 1'b1;
    step(); chk_o("fifo1", O_FIFO);
    fsm_idle = 1'b0;
    step(); chk_o("ready_back", O_IDLE);

    // one-cycle enable pulse: full clear, no Run
    enable = 1'b1;
    step(); chk_o("pulse_ht1", O_HT); chk("cnt2", 32'(enable_cnt), 32'd2);
    enable = 1'b0;
    step(); chk_o("pulse_ht2", O_HT);
    step(); chk_o("pulse_wait1", O_WAIT);
    step(); chk_o("pulse_wait2", O_WAIT);
    fsm_idle = 1'b1;
    step(); chk_o("pulse_fifo", O_FIFO);
    fsm_idle = 1'b0;
    step(); chk_o("pulse_idle", O_IDLE);

    // enable high through WaitIdle/FifoClr: ready for exactly one cycle, then re-run
    enable = 1'b1;
    step(); step(); step(); chk_o("hold_run", O_RUN);
    enable = 1'b0;
    step(); chk_o("hold_wait", O_WAIT);
    enable = 1'b1;
    step(); chk_o("hold_wait_ignored", O_WAIT);
    fsm_idle = 1'b1;
    step(); chk_o("hold_fifo_ignored", O_FIFO);
    fsm_idle = 1'b0;
    step(); chk_o("hold_ready_once", O_IDLE); chk("hold_cnt3", 32'(enable_cnt), 32'd3);
    step(); chk_o("hold_reht", O_HT); chk("hold_cnt4", 32'(enable_cnt), 32'd4);
    step(); step(); chk_o("hold_rerun", O_RUN);

    // fsm_idle already high on WaitIdle entry: one-cycle dwell
    enable = 1'b0;
    fsm_idle = 1'b1;
    step(); chk_o("min_dwell_wait", O_WAIT);
    step(); chk_o("min_dwell_fifo", O_FIFO);
    fsm_idle = 1'b0;
    step(); chk_o("min_dwell_idle", O_IDLE);

    // idle wait never answered
    enable = 1'b1;
    step(); step();
    enable = 1'b0;
    step(); chk_o("to_wait_entry", O_WAIT);
`ifdef ENTROPY_SRC_PIPE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    chk_o("to_wait_last", O_WAIT);
    step(); chk_o("to_fire", O_FIFO | O_TO);
    step(); chk_o("to_idle", O_IDLE);
`else
    for (int i = 0; i < 100; i++) step();
    chk_o("no_to_still_wait", O_WAIT);
    fsm_idle = 1'b1;
    step(); chk_o("no_to_fifo", O_FIFO);
    fsm_idle = 1'b0;
    step(); chk_o("no_to_idle", O_IDLE);
`endif

    // asynchronous reset in HtClr
    enable = 1'b1;
    step(); chk_o("arst_ht", O_HT);
    #2 rst = 1'b1;
    #1 chk_o("arst_outs", O_IDLE);
    chk("arst_cnt", 32'(enable_cnt), 32'd0);
    enable = 1'b0;
    #2 rst = 1'b0;
    step(); chk_o("arst_release", O_IDLE);

    // 256 enable pulses: counter saturates at 255
    fsm_idle = 1'b1;
    for (int i = 0; i < 255; i++) begin
      enable = 1'b1;
      step();
      enable = 1'b0;
      step(); step(); step(); step();
    end
    chk("sat_255", 32'(enable_cnt), 32'd255);
    chk_o("sat_idle", O_IDLE);
    enable = 1'b1;
    step(); chk("sat_hold", 32'(enable_cnt), 32'd255);
    enable = 1'b0;
    step(); step(); step(); step();
    chk_o("sat_final_idle", O_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
